// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// reset PC default and the width of the memory-timeout counter.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_FAULT   = 2'd3
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Wide enough for the default 255-cycle timeout.
    localparam int unsigned TIMER_W = 8;

endpackage : cpu_pkg

// File: rtl/fetch_timer.sv
// Counts cycles spent waiting on memory.
// 'expired' is high combinationally in the cycle that completes LIMIT waiting cycles.
module fetch_timer
    import cpu_pkg::*;
#(
    parameter int unsigned W     = TIMER_W,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear dominates, otherwise advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == LAST);

endmodule : fetch_timer

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory read per FetchReq, delivers the
// word with a one-cycle IW strobe, handles PC redirects mid-flight by
// discarding the stale response, and latches a sticky Fault on memory timeout.
//
// Memory handshake: MemReq is registered and, once raised, stays high with
// MemAddr stable until a cycle where MemAck is sampled high; that cycle
// completes the transfer and MemRdata is only looked at in that cycle.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FetchReq,
    input  logic        PCLoad,
    input  logic [15:0] PCIn,
    input  logic        MemAck,
    input  logic [15:0] MemRdata,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    output logic [15:0] Instr,
    output logic        IW,
    output logic [15:0] PC,
    output logic        Busy,
    output logic        Fault,
    output logic [1:0]  DbgState
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         mem_req_q, mem_req_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic [15:0]  instr_q, instr_d;
    logic         iw_q, iw_d;
    logic         fault_q, fault_d;

    logic         timer_en;
    logic         timer_clr;
    logic         timer_expired;

    // Timer runs only while a request is outstanding; it keeps counting
    // across a WAIT->DISCARD redirect so the total wait is bounded.
    always_comb begin
        timer_en  = (state_q == S_WAIT) || (state_q == S_DISCARD);
        timer_clr = !timer_en;
    end

    fetch_timer #(
        .W     (TIMER_W),
        .LIMIT (TIMEOUT)
    ) u_fetch_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Next-state and next-output logic; MemAck takes priority over timeout.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        iw_d       = 1'b0;
        fault_d    = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (PCLoad) begin
                    pc_d = PCIn;
                end
                if (FetchReq) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = PCLoad ? PCIn : pc_q;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (MemAck && PCLoad) begin
                    pc_d      = PCIn;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (MemAck) begin
                    instr_d   = MemRdata;
                    iw_d      = 1'b1;
                    pc_d      = pc_q + 16'd1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (PCLoad) begin
                    pc_d    = PCIn;
                    state_d = S_DISCARD;
                end else if (timer_expired) begin
                    fault_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_FAULT;
                end
            end

            S_DISCARD: begin
                if (PCLoad) begin
                    pc_d = PCIn;
                end
                if (MemAck) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (timer_expired) begin
                    fault_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_FAULT;
                end
            end

            S_FAULT: begin
                // Locked until reset.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
            instr_q    <= 16'h0000;
            iw_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            iw_q       <= iw_d;
            fault_q    <= fault_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemAddr  = mem_addr_q;
    assign Instr    = instr_q;
    assign IW       = iw_q;
    assign PC       = pc_q;
    assign Busy     = (state_q != S_IDLE);
    assign Fault    = fault_q;
    assign DbgState = state_q;

endmodule : instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, max MemAck wait cycles before Fault.
REQ-003 SHALL have: CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have: RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have: FetchReq  input  1  control requests one instruction fetch.
REQ-006 SHALL have: PCLoad  input  1  redirect PC (branch/jump).
REQ-007 SHALL have: PCIn  input  16  redirect target.
REQ-008 SHALL have: MemAck  input  1  memory read data valid.
REQ-009 SHALL have: MemRdata  input  16  memory read data.
REQ-010 SHALL have: MemReq  output  1  memory read request, registered.
REQ-011 SHALL have: MemAddr  output  16  word address of request, registered.
REQ-012 SHALL have: Instr  output  16  fetched instruction, feeds instruction register.
REQ-013 SHALL have: IW  output  1  one-cycle instruction-register write strobe.
REQ-014 SHALL have: PC  output  16  current PC (address of next fetch).
REQ-015 SHALL have: Busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have: Fault  output  1  sticky memory-timeout flag.

Function
REQ-017 SHALL implement states IDLE, WAIT, DISCARD, FAULT.
REQ-018 IDLE + FetchReq (no PCLoad): SHALL assert MemReq and set MemAddr=PC next cycle, go to WAIT.
REQ-019 IDLE + PCLoad: SHALL set PC=PCIn; if FetchReq is also high, SHALL fetch from PCIn (MemAddr=PCIn) and go to WAIT.
REQ-020 WAIT: SHALL hold MemReq=1 and MemAddr stable until MemAck is sampled high.
REQ-021 WAIT + MemAck (no PCLoad): SHALL register Instr=MemRdata, pulse IW for exactly the following cycle, set PC=PC+1 (16-bit wrap, FFFF->0000), deassert MemReq, and return to IDLE.
REQ-022 WAIT + PCLoad without MemAck: SHALL set PC=PCIn and go to DISCARD; MemReq stays high.
REQ-023 DISCARD: on MemAck, SHALL drop the data (no IW, Instr unchanged, PC unchanged), deassert MemReq, and go to IDLE.
REQ-024 WAIT + PCLoad + MemAck in the same cycle: SHALL drop the data, set PC=PCIn, and go to IDLE.
REQ-025 DISCARD + PCLoad: SHALL overwrite PC with the newer PCIn.
REQ-026 SHALL ignore FetchReq outside IDLE (no queuing).
REQ-027 Latency: FetchReq sampled at edge n gives MemReq high from edge n; MemAck sampled at edge m gives IW high in cycle m..m+1; zero-wait memory gives IW two cycles after FetchReq.
REQ-028 SHALL count WAIT/DISCARD cycles; after TIMEOUT cycles without MemAck, SHALL go to FAULT, set Fault=1, and deassert MemReq.
REQ-029 FAULT: SHALL ignore all inputs; only reset exits.
REQ-030 Instr SHALL hold its value except on a REQ-021 load.

Reset
REQ-031 RST_N low SHALL immediately give: state=IDLE, PC=RESET_PC, MemReq=0, MemAddr=0, Instr=0, IW=0, Busy=0, Fault=0, timeout counter=0.
REQ-032 Reset during WAIT SHALL abandon the transaction; a late MemAck after reset SHALL be ignored while in IDLE.

Structure
REQ-033 State encoding, RESET_PC default and timeout-counter width SHALL live in shared package cpu_pkg.
REQ-034 The timeout counter SHALL be sub-module fetch_timer (clear, enable, expired); all other logic is inline.

Verification
REQ-035 Reset, PC=0, FetchReq pulse, MemAck with MemRdata=16'h1234 one cycle later -> MemAddr=0, Instr=16'h1234, single IW pulse, PC=1.
REQ-036 FetchReq, MemAck held off 5 cycles -> MemReq and MemAddr stable for 5 cycles, IW exactly once, Busy high throughout.
REQ-037 PCLoad=1 with PCIn=16'h0040 during WAIT, MemAck 2 cycles later with 16'hBEEF -> no IW, Instr unchanged, PC=16'h0040; next fetch uses MemAddr=16'h0040.
REQ-038 PC=16'hFFFF, completed fetch -> PC=16'h0000; PCLoad+FetchReq in IDLE with PCIn=16'h0100 -> MemAddr=16'h0100.
REQ-039 FetchReq, no MemAck for TIMEOUT=255 cycles -> Fault=1, MemReq=0, later FetchReq ignored; RST_N low -> Fault=0, PC=RESET_PC.
REQ-040 RST_N asserted mid-WAIT, asynchronous to CLK -> outputs reach reset values without waiting for a clock edge; a stray MemAck afterwards gives no IW.
